muldiv_arbiter: RTL and testbench
=================================

MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 40: watchdog limit, in cycles, on the wait for md_done.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports reqN_valid  input  1  request from requester N (N=0,1).
REQ-005 SHALL have ports reqN_ready  output  1  request accepted on valid&ready (N=0,1).
REQ-006 SHALL have ports reqN_A, reqN_B  input  32  operands (N=0,1).
REQ-007 SHALL have ports reqN_op_mul, reqN_op_div  input  2  operation codes; reqN_sel  input  1  1=divide, 0=multiply (N=0,1).
REQ-008 SHALL have ports respN_valid  output  1  one-cycle result strobe to requester N (N=0,1).
REQ-009 SHALL have ports resp_R  output  32  result; resp_err  output  1  watchdog abort flag.
REQ-010 SHALL have ports md_start  output  1; md_A, md_B  output  32; md_op_mul, md_op_div  output  2; md_sel  output  1. These drive the shared multiply/divide unit.
REQ-011 SHALL have ports md_R  input  32; md_done  input  1. These are the unit's result and completion.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: reqN_ready SHALL be 1 only for the granted requester. The grant goes to the sole valid requester; when both are valid, the one not served last wins (round-robin pointer, reset value 0 => requester 0 wins first tie).
REQ-014 On acceptance SHALL latch operands, ops, sel and requester id, then move to ISSUE.
REQ-015 ISSUE SHALL assert md_start for exactly one cycle, then move to WAIT.
REQ-016 md_A/md_B/md_op_*/md_sel SHALL hold the latched values from ISSUE through the end of WAIT.
REQ-017 WAIT SHALL capture md_R into resp_R on the first cycle md_done=1, then move to RESP.
REQ-018 WAIT SHALL count cycles; if md_done is still 0 after MAX_CYCLES cycles, it SHALL set resp_R=0 and resp_err=1 and move to RESP.
REQ-019 RESP SHALL pulse respN_valid for the latched id for one cycle, flip the round-robin pointer, and return to IDLE.
REQ-020 resp_R and resp_err SHALL remain stable until the next RESP.
REQ-021 Latency from accept (cycle T) to respN_valid SHALL be: md_start at T+1, resp at done_cycle+1.
REQ-022 Both ready signals SHALL be 0 outside IDLE, so no new request is taken while busy.
REQ-023 md_done arriving in IDLE, ISSUE or RESP SHALL be ignored.

Reset
REQ-024 reset=0 at a clock edge SHALL force IDLE and pointer=0. It SHALL clear md_start, reqN_ready, respN_valid, resp_err, resp_R, md_* outputs and the watchdog counter to 0.
REQ-025 Reset asserted mid-operation (ISSUE/WAIT) SHALL abort without issuing respN_valid.

Configuration
REQ-026 With macro MULDIV_REUSE_EN defined, the block SHALL store the last completed non-error operands/ops/sel/result plus a valid bit (cleared by reset).
REQ-027 With MULDIV_REUSE_EN defined, an accepted request fully matching the stored entry SHALL go IDLE->RESP, with no md_start and resp_R = stored result. Otherwise the request SHALL follow normal flow.
REQ-028 Without MULDIV_REUSE_EN, every accepted request SHALL go through ISSUE/WAIT.

Verification
REQ-029 Single request: req0 A=6, B=7, mul, with md_done 3 cycles after md_start and md_R=42 -> md_start one cycle at T+1; resp0_valid=1 and resp_R=42 one cycle after done; resp_err=0.
REQ-030 Tie: req0 and req1 valid together from reset -> req0 served first, then req1 without a gap beyond one IDLE cycle; resp1_valid only for the second result.
REQ-031 Watchdog: md_done held 0 -> after 40 WAIT cycles, resp0_valid=1, resp_R=0, resp_err=1; next request proceeds normally.
REQ-032 Reset mid-WAIT: reset=0 for one cycle -> no respN_valid; all outputs 0; a fresh request is accepted afterwards.
REQ-033 MULDIV_REUSE_EN: repeat A=100, B=7, div -> second response comes one cycle after accept with no md_start and the same resp_R; a changed B reissues to the unit.

Source files
------------

// File: rtl/muldiv_arbiter.sv
// Two-requester round-robin front end for a shared multiply/divide unit, with a done watchdog.
// Optional MULDIV_REUSE_EN: replay the last good result when an identical request arrives.
module muldiv_arbiter #(
  parameter int MAX_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [1:0]  req0_op_mul,
  input  logic [1:0]  req0_op_div,
  input  logic        req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [1:0]  req1_op_mul,
  input  logic [1:0]  req1_op_div,
  input  logic        req1_sel,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_R,
  output logic        resp_err,
  output logic        md_start,
  output logic [31:0] md_A,
  output logic [31:0] md_B,
  output logic [1:0]  md_op_mul,
  output logic [1:0]  md_op_div,
  output logic        md_sel,
  input  logic [31:0] md_R,
  input  logic        md_done
);

  localparam int NUM_REQ = 2;
  localparam int CW      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op_mul;
    logic [1:0]  op_div;
    logic        sel;
  } md_req_t;

  state_t                 state_q, state_d;
  md_req_t [NUM_REQ-1:0]  req;
  logic    [NUM_REQ-1:0]  vld, rdy, rsp;
  md_req_t                op_q;
  logic                   id_q, ptr_q;
  logic                   gnt, accept, timeout, hit;
  logic    [31:0]         hit_r;
  logic    [CW-1:0]       cnt_q;

  assign vld    = {req1_valid, req0_valid};
  assign req[0] = {req0_A, req0_B, req0_op_mul, req0_op_div, req0_sel};
  assign req[1] = {req1_A, req1_B, req1_op_mul, req1_op_div, req1_sel};

  // ptr_q names the requester that wins a tie; a lone requester always wins.
  always_comb begin
    gnt = ptr_q;
    if (vld != 2'b11) gnt = vld[1];
  end

  // Gating with reset keeps ready low during the reset cycle itself.
  assign accept  = reset && (state_q == IDLE) && (|vld);
  assign timeout = (cnt_q == CW'(MAX_CYCLES - 1));

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_lane
      assign rdy[i] = accept && (gnt == 1'(i));
      assign rsp[i] = (state_q == RESP) && (id_q == 1'(i));
    end
  endgenerate

  assign req0_ready  = rdy[0];
  assign req1_ready  = rdy[1];
  assign resp0_valid = rsp[0];
  assign resp1_valid = rsp[1];

  assign md_start  = (state_q == ISSUE);
  assign md_A      = op_q.a;
  assign md_B      = op_q.b;
  assign md_op_mul = op_q.op_mul;
  assign md_op_div = op_q.op_div;
  assign md_sel    = op_q.sel;

`ifdef MULDIV_REUSE_EN
  logic    cache_vld_q;
  md_req_t cache_op_q;
  logic [31:0] cache_r_q;

  assign hit   = cache_vld_q && (cache_op_q == req[gnt]);
  assign hit_r = cache_r_q;

  // Only clean completions are remembered; watchdog aborts never populate the entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cache_vld_q <= 1'b0;
      cache_op_q  <= '0;
      cache_r_q   <= '0;
    end else if (state_q == WAIT && md_done) begin
      cache_vld_q <= 1'b1;
      cache_op_q  <= op_q;
      cache_r_q   <= md_R;
    end
  end
`else
  assign hit   = 1'b0;
  assign hit_r = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = hit ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (md_done || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q     <= '0;
      id_q     <= 1'b0;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      resp_R   <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q  <= req[gnt];
          id_q  <= gnt;
          cnt_q <= '0;
          if (hit) begin
            resp_R   <= hit_r;
            resp_err <= 1'b0;
          end
        end
        WAIT: begin
          // done wins over the watchdog when both land on the same cycle
          if (md_done) begin
            resp_R   <= md_R;
            resp_err <= 1'b0;
          end else if (timeout) begin
            resp_R   <= '0;
            resp_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    ptr_q <= ~id_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed, table-driven bench for muldiv_arbiter; the bench plays the multiply/divide unit.
module tb_muldiv_arbiter;
  localparam int MAXC = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic [1:0]  req0_op_mul = '0, req0_op_div = '0, req1_op_mul = '0, req1_op_div = '0;
  logic        req0_sel = 1'b0, req1_sel = 1'b0;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_R;
  logic        resp_err;
  logic        md_start;
  logic [31:0] md_A, md_B;
  logic [1:0]  md_op_mul, md_op_div;
  logic        md_sel;
  logic [31:0] md_R = '0;
  logic        md_done = 1'b0;

  muldiv_arbiter #(.MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_op_mul(req0_op_mul), .req0_op_div(req0_op_div), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_op_mul(req1_op_mul), .req1_op_div(req1_op_div), .req1_sel(req1_sel),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_R(resp_R), .resp_err(resp_err),
    .md_start(md_start), .md_A(md_A), .md_B(md_B), .md_op_mul(md_op_mul),
    .md_op_div(md_op_div), .md_sel(md_sel), .md_R(md_R), .md_done(md_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rq;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  opm;
    logic [1:0]  opd;
    logic        sel;
    int          delay;   // cycles after md_start that md_done rises; 0 = never
    logic [31:0] md_r;
    logic [31:0] exp_r;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int rq);
    return (rq == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rv(input int rq);
    return (rq == 0) ? resp0_valid : resp1_valid;
  endfunction

  task automatic set_req(input int rq, input logic v, input vec_t x);
    if (rq == 0) begin
      req0_valid = v; req0_A = x.a; req0_B = x.b;
      req0_op_mul = x.opm; req0_op_div = x.opd; req0_sel = x.sel;
    end else begin
      req1_valid = v; req1_A = x.a; req1_B = x.b;
      req1_op_mul = x.opm; req1_op_div = x.opd; req1_sel = x.sel;
    end
  endtask

  // Full accept -> ISSUE -> WAIT -> RESP transaction with the bench acting as the unit.
  task automatic run_op(input string tag, input vec_t v, output int waited);
    int n;
    set_req(v.rq, 1'b1, v);
    #1;
    waited = 0;
    while (!rdy(v.rq) && waited < 20) begin
      tick();
      waited++;
    end
    chk(tag, "ready", 32'(rdy(v.rq)), 32'd1);
    chk(tag, "other_ready", 32'(rdy(1 - v.rq)), 32'd0);
    tick();
    set_req(v.rq, 1'b0, v);
    chk(tag, "md_start", 32'(md_start), 32'd1);
    chk(tag, "md_A", md_A, v.a);
    chk(tag, "md_B", md_B, v.b);
    chk(tag, "md_ops", {27'd0, md_op_mul, md_op_div, md_sel}, {27'd0, v.opm, v.opd, v.sel});
    n = (v.delay == 0) ? MAXC : v.delay;
    for (int k = 1; k <= n; k++) begin
      tick();
      md_done = (k == v.delay);
      md_R    = (k == v.delay) ? v.md_r : 32'hDEAD_BEEF;
      if (k == 1) begin
        chk(tag, "start_once", 32'(md_start), 32'd0);
        chk(tag, "busy_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      if (k == n) chk(tag, "no_early_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    end
    tick();
    md_done = 1'b0;
    chk(tag, "resp_valid", 32'(rv(v.rq)), 32'd1);
    chk(tag, "other_resp", 32'(rv(1 - v.rq)), 32'd0);
    chk(tag, "resp_R", resp_R, v.exp_r);
    chk(tag, "resp_err", 32'(resp_err), 32'(v.exp_err));
    tick();
    chk(tag, "resp_pulse", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk(tag, "resp_R_hold", resp_R, v.exp_r);
    chk(tag, "resp_err_hold", 32'(resp_err), 32'(v.exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   w;
    vec_t t0, t1, r, d;

    vecs[0] = '{0, 32'd6,          32'd7,       2'b00, 2'b00, 1'b0, 3,  32'd42,       32'd42,       1'b0};
    vecs[1] = '{1, 32'd100,        32'd7,       2'b00, 2'b00, 1'b1, 1,  32'd14,       32'd14,       1'b0};
    vecs[2] = '{0, 32'h0000_FFFF,  32'h0001_0001, 2'b01, 2'b00, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{1, 32'hFFFF_FFF9,  32'd2,       2'b00, 2'b01, 1'b1, 2,  32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{0, 32'd5,          32'd5,       2'b00, 2'b00, 1'b0, 0,  32'd0,        32'd0,        1'b1};
    vecs[5] = '{0, 32'd3,          32'd4,       2'b00, 2'b00, 1'b0, 2,  32'd12,       32'd12,       1'b0};
    vecs[6] = '{1, 32'd9,          32'd3,       2'b10, 2'b00, 1'b1, 40, 32'd3,        32'd3,        1'b0};

    // Reset state, with a request pending to show ready stays low.
    req0_valid = 1'b1;
    tick();
    tick();
    chk("reset", "ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("reset", "md_start", 32'(md_start), 32'd0);
    chk("reset", "resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("reset", "resp_R", resp_R, 32'd0);
    chk("reset", "resp_err", 32'(resp_err), 32'd0);
    chk("reset", "md_bus", md_A | md_B | {27'd0, md_op_mul, md_op_div, md_sel}, 32'd0);
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Tie straight out of reset: requester 0 first, requester 1 in the very next IDLE cycle.
    t0 = '{0, 32'd2, 32'd8, 2'b00, 2'b00, 1'b0, 2, 32'd16, 32'd16, 1'b0};
    t1 = '{1, 32'd20, 32'd4, 2'b00, 2'b00, 1'b1, 3, 32'd5, 32'd5, 1'b0};
    set_req(1, 1'b1, t1);
    run_op("tie0", t0, w);
    run_op("tie1", t1, w);
    chk("tie1", "gap", 32'(w), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], w);
    end

    // Reset in the middle of WAIT: no response, outputs cleared, late done ignored.
    r = '{0, 32'd11, 32'd11, 2'b00, 2'b00, 1'b0, 2, 32'd121, 32'd121, 1'b0};
    set_req(0, 1'b1, r);
    tick();
    set_req(0, 1'b0, r);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("midrst", "resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("midrst", "md_start", 32'(md_start), 32'd0);
    chk("midrst", "resp_R", resp_R, 32'd0);
    chk("midrst", "md_A", md_A, 32'd0);
    reset = 1'b1;
    md_done = 1'b1;
    md_R = 32'd121;
    tick();
    md_done = 1'b0;
    chk("midrst", "stray_done", {30'd0, resp1_valid, resp0_valid, md_start}, 32'd0);
    tick();
    chk("midrst", "stray_done2", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    run_op("postrst", r, w);

    // Repeat of an identical request.
    d = '{0, 32'd100, 32'd7, 2'b00, 2'b00, 1'b1, 2, 32'd14, 32'd14, 1'b0};
    run_op("reuse_a", d, w);
`ifdef MULDIV_REUSE_EN
    set_req(0, 1'b1, d);
    #1;
    chk("reuse_b", "ready", 32'(req0_ready), 32'd1);
    tick();
    set_req(0, 1'b0, d);
    chk("reuse_b", "md_start", 32'(md_start), 32'd0);
    chk("reuse_b", "resp_valid", 32'(resp0_valid), 32'd1);
    chk("reuse_b", "resp_R", resp_R, 32'd14);
    chk("reuse_b", "resp_err", 32'(resp_err), 32'd0);
    tick();
    chk("reuse_b", "after", {30'd0, resp0_valid, md_start}, 32'd0);
`else
    run_op("reuse_b", d, w);
`endif
    d.b = 32'd8; d.md_r = 32'd12; d.exp_r = 32'd12;
    run_op("reuse_c", d, w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
